// File: rtl/bcd_counter_display_mux.sv
// N-digit BCD up/down counter with prescaled stepping and a time-multiplexed
// 7-segment driver: one registered segment bus scanned across N_DIGITS digits.
module bcd_counter_display_mux #(
   parameter int N_DIGITS       = 4,
   parameter int TICK_DIV       = 50_000_000,
   parameter int SCAN_DIV       = 50_000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up_down,
   input  logic                  clear,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] load_value,
   output logic [4*N_DIGITS-1:0] count_bcd,
   output logic                  wrap_pulse,
   output logic [N_DIGITS-1:0]   digit_sel,
   output logic [6:0]            seven_segment_out
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX  = IW'(N_DIGITS - 1);
   localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   typedef logic [N_DIGITS-1:0][3:0] bcd_t;

   logic [PW-1:0]       pre_q;
   logic [SW-1:0]       scan_q;
   logic [IW-1:0]       idx_q;
   bcd_t                count_q;
   bcd_t                step_d;
   bcd_t                load_d;
   logic                carry;
   logic                tick;
   logic                wrap_q;
   logic [N_DIGITS-1:0] sel_q;
   logic [6:0]          seg_q;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return SEG_ACTIVE_LOW ? ~p : p;
   endfunction

   assign tick = en && (pre_q == PRE_MAX);

   // Ripple a carry (up) or borrow (down) from digit0; carry surviving past the
   // top digit means the whole count wrapped.
   // NOTE: every always_comb output is given a default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      step_d = count_q;
      carry  = 1'b1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (carry) begin
            if (up_down) begin
               if (count_q[i] == 4'd9) begin
                  step_d[i] = 4'd0;
               end else begin
                  step_d[i] = count_q[i] + 4'd1;
                  carry     = 1'b0;
               end
            end else begin
               if (count_q[i] == 4'd0) begin
                  step_d[i] = 4'd9;
               end else begin
                  step_d[i] = count_q[i] - 4'd1;
                  carry     = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      load_d = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         load_d[i] = (load_value[4*i +: 4] > 4'd9) ? 4'd0 : load_value[4*i +: 4];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else if (clear) begin
         count_q <= '0;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else if (load) begin
         count_q <= load_d;
         pre_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         wrap_q <= tick && carry;
         if (tick) begin
            count_q <= step_d;
            pre_q   <= '0;
         end else if (en) begin
            pre_q <= pre_q + PW'(1);
         end
      end
   end

   // Scan timing is free-running: clear, load and en never disturb it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_q <= '0;
         idx_q  <= '0;
      end else if (scan_q == SCAN_MAX) begin
         scan_q <= '0;
         idx_q  <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
      end else begin
         scan_q <= scan_q + SW'(1);
      end
   end

   // Select and pattern come from the same index on the same edge, so they never disagree.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_q <= N_DIGITS'(1);
         seg_q <= SEG_OFF;
      end else begin
         sel_q <= N_DIGITS'(1) << idx_q;
         seg_q <= decode(count_q[idx_q]);
      end
   end

   assign count_bcd         = count_q;
   assign wrap_pulse        = wrap_q;
   assign digit_sel         = sel_q;
   assign seven_segment_out = seg_q;

endmodule
